data_table_ram: RTL

//  Slave/responder end of data_table_if: owns the hash-table data RAM (2**A_WIDTH x ram_data_t).

---
 rtl/data_table_ram.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_table_ram.sv
// ---------------------------------------------------------------------------
// data_table_ram
//   Responder end of the hash-table data interface. Owns the table RAM
//   (2**A_WIDTH entries of DATA_W bits) and serves one read and one write per
//   cycle. Reads have a fixed latency of RD_LATENCY cycles, are fully pipelined
//   and are write-first against a same-cycle write to the same address. A clear
//   sweep zeroes every entry after reset (INIT_ON_RESET=1) or on clear_i.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   dt_rd_addr_i   read address
//   dt_rd_en_i     read request (accepted every cycle, also during a sweep)
//   dt_wr_addr_i   write address
//   dt_wr_data_i   write data
//   dt_wr_en_i     write request (dropped during a sweep)
//   dt_rd_data_o   read result; holds the last result while rd_valid_o is low
//   clear_i        start a clear sweep (sampled only when ready)
//   rd_valid_o     dt_rd_data_o carries a read result this cycle
//   init_done_o    table is ready for use
// ---------------------------------------------------------------------------
module data_table_ram #(
    parameter int unsigned RD_LATENCY    = 2,     // legal 1..4
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter int unsigned A_WIDTH       = 4,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [A_WIDTH-1:0] dt_rd_addr_i,
    input  logic              dt_rd_en_i,
    input  logic [A_WIDTH-1:0] dt_wr_addr_i,
    input  logic [DATA_W-1:0] dt_wr_data_i,
    input  logic              dt_wr_en_i,
    output logic [DATA_W-1:0] dt_rd_data_o,
    input  logic              clear_i,
    output logic              rd_valid_o,
    output logic              init_done_o
);

    localparam int unsigned Depth = 2 ** A_WIDTH;
    // Sweep counter is one bit wider so the terminal compare never sees a wrap.
    localparam logic [A_WIDTH:0] ClrLast = (A_WIDTH + 1)'(Depth - 1);

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e             state_q;
    logic [A_WIDTH:0]   clr_addr_q;
    logic               init_done_q;

    logic [DATA_W-1:0]  mem [Depth];

    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  rd_cap_data;

    logic [RD_LATENCY-1:0][DATA_W-1:0] pipe_data_q;
    logic [RD_LATENCY-1:0]             pipe_vld_q;

    // ------------------------------------------------------------------
    // Control FSM: sweep counter and ready flag live in the same block.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT_ON_RESET ? StClear : StReady;
            clr_addr_q  <= '0;
            init_done_q <= ~INIT_ON_RESET;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_addr_q <= clr_addr_q + (A_WIDTH + 1)'(1);
                    if (clr_addr_q == ClrLast) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (clear_i) begin
                        state_q     <= StClear;
                        clr_addr_q  <= '0;
                        init_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StReady;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port: the sweep owns the port while clearing, user writes drop.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = dt_wr_en_i;
        mem_waddr = dt_wr_addr_i;
        mem_wdata = dt_wr_data_i;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q[A_WIDTH-1:0];
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read capture at issue: reads during a sweep return zero; a same-cycle
    // write to the same address is forwarded (write-first).
    // ------------------------------------------------------------------
    always_comb begin
        rd_cap_data = mem[dt_rd_addr_i];
        if (state_q == StClear) begin
            rd_cap_data = '0;
        end else if (dt_wr_en_i && (dt_wr_addr_i == dt_rd_addr_i)) begin
            rd_cap_data = dt_wr_data_i;
        end
    end

    // Data stages load only behind a valid, so the last stage holds the most
    // recent result while no read is completing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_data_q <= '0;
            pipe_vld_q  <= '0;
        end else begin
            pipe_vld_q[0] <= dt_rd_en_i;
            if (dt_rd_en_i) begin
                pipe_data_q[0] <= rd_cap_data;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign dt_rd_data_o = pipe_data_q[RD_LATENCY-1];
    assign rd_valid_o   = pipe_vld_q[RD_LATENCY-1];
    assign init_done_o  = init_done_q;

endmodule
